// File: rtl/ysyx_reg_rat.sv
// ysyx_reg_rat: architectural register file with a per-register producer
// table (busy bit + ROB tag). It takes dispatches from the IDU and commits
// from the ROB, and serves two operand read ports for issue.
// Optional feature: define YSYX_REG_RAT_BYPASS_EN so that same-cycle commits
// are forwarded to the read ports. Without it, reads come only from
// registered state.
module ysyx_reg_rat #(
  parameter int XLEN       = 32,
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int TAG_W      = 4,
  parameter int NR_COM     = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         idu_valid,
  input  logic [REG_ADDR_W-1:0]        idu_rd,
  input  logic [TAG_W-1:0]             idu_tag,
  input  logic                         flush,
  input  logic [NR_COM-1:0]            com_valid,
  input  logic [NR_COM*REG_ADDR_W-1:0] com_rd,
  input  logic [NR_COM*TAG_W-1:0]      com_tag,
  input  logic [NR_COM*XLEN-1:0]       com_data,
  input  logic [REG_ADDR_W-1:0]        rs1,
  input  logic [REG_ADDR_W-1:0]        rs2,
  output logic [XLEN-1:0]              src1,
  output logic [XLEN-1:0]              src2,
  output logic                         busy1,
  output logic                         busy2,
  output logic [TAG_W-1:0]             tag1,
  output logic [TAG_W-1:0]             tag2,
  output logic [REG_NUM-1:0]           busy_vec
);

  // Architectural state and producer table
  logic [XLEN-1:0]    rf_q   [REG_NUM];
  logic [XLEN-1:0]    rf_d   [REG_NUM];
  logic [TAG_W-1:0]   tag_q  [REG_NUM];
  logic [TAG_W-1:0]   tag_d  [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;

  // Unpacked views of the packed commit buses
  logic [REG_ADDR_W-1:0] com_rd_a   [NR_COM];
  logic [TAG_W-1:0]      com_tag_a  [NR_COM];
  logic [XLEN-1:0]       com_data_a [NR_COM];

  genvar gi;
  generate
    for (gi = 0; gi < NR_COM; gi++) begin : g_com_unpack
      assign com_rd_a[gi]   = com_rd[gi*REG_ADDR_W +: REG_ADDR_W];
      assign com_tag_a[gi]  = com_tag[gi*TAG_W +: TAG_W];
      assign com_data_a[gi] = com_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Next state: commits first (ascending port index so the youngest wins),
  // then dispatch overrides busy/tag, and flush overrides everything in the
  // table. The tag compare uses the registered tag, so a commit never
  // matches a producer that is only being dispatched this cycle.
  always_comb begin
    rf_d   = rf_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    for (int i = 0; i < NR_COM; i++) begin
      if (com_valid[i] && (com_rd_a[i] != '0)) begin
        rf_d[com_rd_a[i]] = com_data_a[i];
        if (tag_q[com_rd_a[i]] == com_tag_a[i]) begin
          busy_d[com_rd_a[i]] = 1'b0;
        end
      end
    end
    if (flush) begin
      busy_d = '0;
      for (int r = 0; r < REG_NUM; r++) begin
        tag_d[r] = '0;
      end
    end else if (idu_valid && (idu_rd != '0)) begin
      busy_d[idu_rd] = 1'b1;
      tag_d[idu_rd]  = idu_tag;
    end
    // x0 is hard-wired: never busy, never written
    busy_d[0] = 1'b0;
    tag_d[0]  = '0;
    rf_d[0]   = '0;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      for (int r = 0; r < REG_NUM; r++) begin
        rf_q[r]  <= '0;
        tag_q[r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int r = 0; r < REG_NUM; r++) begin
        rf_q[r]  <= rf_d[r];
        tag_q[r] <= tag_d[r];
      end
    end
  end

  // Read ports
  logic [REG_ADDR_W-1:0] rs_a       [2];
  logic [XLEN-1:0]       rd_data_a  [2];
  logic                  rd_busy_a  [2];
  logic [TAG_W-1:0]      rd_tag_a   [2];

  assign rs_a[0] = rs1;
  assign rs_a[1] = rs2;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      // Operand lookup; the optional bypass forwards the youngest matching
      // commit and drops busy when that commit retires the current producer
      always_comb begin
        rd_data_a[gi] = (rs_a[gi] == '0) ? '0 : rf_q[rs_a[gi]];
        rd_busy_a[gi] = busy_q[rs_a[gi]];
`ifdef YSYX_REG_RAT_BYPASS_EN
        for (int i = 0; i < NR_COM; i++) begin
          if (com_valid[i] && (rs_a[gi] != '0) && (com_rd_a[i] == rs_a[gi])) begin
            rd_data_a[gi] = com_data_a[i];
            rd_busy_a[gi] = (com_tag_a[i] == tag_q[rs_a[gi]]) ? 1'b0 : busy_q[rs_a[gi]];
          end
        end
`endif
        rd_tag_a[gi] = rd_busy_a[gi] ? tag_q[rs_a[gi]] : '0;
      end
    end
  endgenerate

  assign src1     = rd_data_a[0];
  assign src2     = rd_data_a[1];
  assign busy1    = rd_busy_a[0];
  assign busy2    = rd_busy_a[1];
  assign tag1     = rd_tag_a[0];
  assign tag2     = rd_tag_a[1];
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_ysyx_reg_rat.sv
// Directed testbench for ysyx_reg_rat (default parameters).
module tb_ysyx_reg_rat;

  logic        clock = 1'b0;
  logic        reset;
  logic        idu_valid;
  logic [4:0]  idu_rd;
  logic [3:0]  idu_tag;
  logic        flush;
  logic [1:0]  com_valid;
  logic [9:0]  com_rd;
  logic [7:0]  com_tag;
  logic [63:0] com_data;
  logic [4:0]  rs1, rs2;
  logic [31:0] src1, src2;
  logic        busy1, busy2;
  logic [3:0]  tag1, tag2;
  logic [31:0] busy_vec;

  int checks = 0;
  int errors = 0;

  ysyx_reg_rat dut (
    .clock(clock), .reset(reset),
    .idu_valid(idu_valid), .idu_rd(idu_rd), .idu_tag(idu_tag),
    .flush(flush),
    .com_valid(com_valid), .com_rd(com_rd), .com_tag(com_tag), .com_data(com_data),
    .rs1(rs1), .rs2(rs2),
    .src1(src1), .src2(src2), .busy1(busy1), .busy2(busy2),
    .tag1(tag1), .tag2(tag2), .busy_vec(busy_vec)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
    end else begin
      $display("ok   %s = 0x%08h", name, obs);
    end
  endtask

  // Advance one clock edge, then let outputs settle
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    idu_valid = 1'b0; idu_rd = '0; idu_tag = '0;
    flush = 1'b0;
    com_valid = '0; com_rd = '0; com_tag = '0; com_data = '0;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic [3:0] tg);
    idu_valid = 1'b1; idu_rd = rd; idu_tag = tg;
  endtask

  task automatic commit(input int port, input logic [4:0] rd, input logic [3:0] tg,
                        input logic [31:0] data);
    com_valid[port]        = 1'b1;
    com_rd[port*5 +: 5]    = rd;
    com_tag[port*4 +: 4]   = tg;
    com_data[port*32 +: 32] = data;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rs1 = 5'd0; rs2 = 5'd0;
    #1;
    check_eq("reset_busy_vec", busy_vec, 32'h0);
    check_eq("reset_src1", src1, 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // T2: dispatch rd5 tag3, then commit it
    dispatch(5'd5, 4'd3);
    tick();
    idle();
    rs1 = 5'd5;
    #1;
    check_eq("t2_busy1", {31'b0, busy1}, 32'd1);
    check_eq("t2_tag1", {28'b0, tag1}, 32'd3);
    check_eq("t2_busy_vec", busy_vec, 32'h0000_0020);
    commit(0, 5'd5, 4'd3, 32'hDEAD_BEEF);
    tick();
    idle();
    check_eq("t2_busy1_clr", {31'b0, busy1}, 32'd0);
    check_eq("t2_src1", src1, 32'hDEAD_BEEF);
    check_eq("t2_tag1_clr", {28'b0, tag1}, 32'd0);

    // T3: stale commit must not clear the newer producer
    dispatch(5'd7, 4'd1);
    tick();
    dispatch(5'd7, 4'd2);
    tick();
    idle();
    commit(1, 5'd7, 4'd1, 32'h11);
    tick();
    idle();
    rs2 = 5'd7;
    #1;
    check_eq("t3_src2", src2, 32'h11);
    check_eq("t3_busy2_stale", {31'b0, busy2}, 32'd1);
    check_eq("t3_tag2", {28'b0, tag2}, 32'd2);
    commit(0, 5'd7, 4'd2, 32'h12);
    tick();
    idle();
    check_eq("t3_busy2_clr", {31'b0, busy2}, 32'd0);
    check_eq("t3_src2_new", src2, 32'h12);

    // T4: both ports to rd9 plus dispatch to rd9
    commit(0, 5'd9, 4'd0, 32'hA);
    commit(1, 5'd9, 4'd0, 32'hB);
    dispatch(5'd9, 4'd4);
    tick();
    idle();
    rs1 = 5'd9;
    #1;
    check_eq("t4_src1", src1, 32'hB);
    check_eq("t4_busy1", {31'b0, busy1}, 32'd1);
    check_eq("t4_tag1", {28'b0, tag1}, 32'd4);

    // Matching-tag commit and new dispatch on the same rd: dispatch wins
    dispatch(5'd13, 4'd2);
    tick();
    commit(0, 5'd13, 4'd2, 32'h77);
    dispatch(5'd13, 4'd3);
    tick();
    idle();
    rs1 = 5'd13;
    #1;
    check_eq("dc_src1", src1, 32'h77);
    check_eq("dc_busy1", {31'b0, busy1}, 32'd1);
    check_eq("dc_tag1", {28'b0, tag1}, 32'd3);

    // T5: regs 3,9,10,13 busy; flush with commit rd3 and dispatch rd6
    dispatch(5'd3, 4'd5);
    tick();
    dispatch(5'd10, 4'd6);
    tick();
    idle();
    #1;
    check_eq("t5_busy_vec_pre", busy_vec, 32'h0000_2608);
    flush = 1'b1;
    commit(0, 5'd3, 4'd5, 32'h33);
    dispatch(5'd6, 4'd9);
    tick();
    idle();
    rs1 = 5'd3; rs2 = 5'd6;
    #1;
    check_eq("t5_busy_vec", busy_vec, 32'h0);
    check_eq("t5_src1", src1, 32'h33);
    check_eq("t5_busy2_r6", {31'b0, busy2}, 32'd0);
    rs2 = 5'd9;
    #1;
    check_eq("t5_rf9_kept", src2, 32'hB);

    // T6: x0 is hard-wired
    dispatch(5'd0, 4'd1);
    commit(0, 5'd0, 4'd1, 32'h55);
    tick();
    idle();
    rs1 = 5'd0;
    #1;
    check_eq("t6_x0_src", src1, 32'h0);
    check_eq("t6_x0_busy", {31'b0, busy1}, 32'd0);
    check_eq("t6_x0_vec", busy_vec, 32'h0);

    // T6: same-cycle commit visibility on a read port
    dispatch(5'd4, 4'd6);
    tick();
    idle();
    commit(0, 5'd4, 4'd6, 32'h44);
    rs1 = 5'd4;
    #1;
`ifdef YSYX_REG_RAT_BYPASS_EN
    check_eq("t6_byp_src1", src1, 32'h44);
    check_eq("t6_byp_busy1", {31'b0, busy1}, 32'd0);
`else
    check_eq("t6_nobyp_src1", src1, 32'h0);
    check_eq("t6_nobyp_busy1", {31'b0, busy1}, 32'd1);
    check_eq("t6_nobyp_tag1", {28'b0, tag1}, 32'd6);
`endif
    tick();
    idle();
    check_eq("t6_after_src1", src1, 32'h44);
    check_eq("t6_after_busy1", {31'b0, busy1}, 32'd0);

    // T1: asynchronous reset mid-run, between clock edges
    dispatch(5'd20, 4'd7);
    tick();
    idle();
    rs1 = 5'd4; rs2 = 5'd3;
    #1;
    check_eq("t1_busy_vec_pre", busy_vec, 32'h0010_0000);
    #1;
    reset = 1'b1;
    #1;
    check_eq("t1_busy_vec", busy_vec, 32'h0);
    check_eq("t1_src1", src1, 32'h0);
    check_eq("t1_src2", src2, 32'h0);
    tick();
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
